// File: rtl/controle_contexto_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// pacote_contexto: state encoding and constants for the context sequencer
// Rev 1.0
// ------------------------------------------------------------------
package pacote_contexto;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    SALVA   = 2'd1,
    CARREGA = 2'd2,
    FIM     = 2'd3
  } estado_t;

  localparam int NUM_REGS = 32;
  localparam int IDX_W    = 5;
  localparam logic [IDX_W-1:0] IDX_ULTIMO = IDX_W'(NUM_REGS - 1);

  localparam int LAT_COMPLETA = 65;
  localparam int LAT_SALVA    = 33;
  localparam int LAT_CARREGA  = 34;
  localparam int LAT_NENHUMA  = 2;

endpackage
`default_nettype wire

// File: rtl/controle_contexto_if.sv
`default_nettype none
// ------------------------------------------------------------------
// controle_contexto_if: request, register-file and data-memory buses
// Rev 1.0
// ------------------------------------------------------------------
interface controle_contexto_if #(
  parameter int PID_W = 3,
  parameter int END_W = 32
);
  logic             inicia;
  logic             salvaEn;
  logic             carregaEn;
  logic [PID_W-1:0] pidSalvar;
  logic [PID_W-1:0] pidCarregar;
  logic             pausa;
  logic             ocupado;
  logic             pronto;
  logic [4:0]       leituraUm;
  logic [31:0]      DadosUm;
  logic [4:0]       regEscrita;
  logic [31:0]      escreveDado;
  logic             escreveReg;
  logic [END_W-1:0] memEnd;
  logic [31:0]      memDadoEsc;
  logic             memEscreve;
  logic [31:0]      memDadoLido;

  modport slave (
    input  inicia, salvaEn, carregaEn, pidSalvar, pidCarregar, pausa, DadosUm, memDadoLido,
    output ocupado, pronto, leituraUm, regEscrita, escreveDado, escreveReg,
           memEnd, memDadoEsc, memEscreve
  );

  modport master (
    output inicia, salvaEn, carregaEn, pidSalvar, pidCarregar, pausa, DadosUm, memDadoLido,
    input  ocupado, pronto, leituraUm, regEscrita, escreveDado, escreveReg,
           memEnd, memDadoEsc, memEscreve
  );
endinterface
`default_nettype wire

// File: rtl/controle_contexto_gerador.sv
`default_nettype none
// ------------------------------------------------------------------
// gerador_endereco_contexto: word address CTX_BASE + {pid, idx}
// Rev 1.0
// ------------------------------------------------------------------
module gerador_endereco_contexto
  import pacote_contexto::*;
#(
  parameter int               PID_W    = 3,
  parameter int               END_W    = 32,
  parameter logic [END_W-1:0] CTX_BASE = END_W'(32'h0000_0F00)
) (
  input  logic [PID_W-1:0] i_pid,
  input  logic [IDX_W-1:0] i_idx,
  output logic [END_W-1:0] o_endereco
);
  assign o_endereco = CTX_BASE + END_W'({i_pid, i_idx});
endmodule
`default_nettype wire

// File: rtl/controle_contexto.sv
`default_nettype none
// ------------------------------------------------------------------
// controle_contexto: saves r1..r31 to a per-PID area, then restores them
// Rev 1.0
// ------------------------------------------------------------------
module controle_contexto
  import pacote_contexto::*;
#(
  parameter int               PID_W    = 3,
  parameter int               END_W    = 32,
  parameter logic [END_W-1:0] CTX_BASE = END_W'(32'h0000_0F00)
) (
  input  logic               clock,
  input  logic               reset,
  controle_contexto_if.slave bus
);

  estado_t          estado_q, estado_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             leitura_valida_q, leitura_valida_d;
  logic             carrega_en_q, carrega_en_d;
  logic [PID_W-1:0] pid_salvar_q, pid_salvar_d;
  logic [PID_W-1:0] pid_carregar_q, pid_carregar_d;

  logic [IDX_W-1:0] w_idx_carga;
  logic [END_W-1:0] w_end_salva;
  logic [END_W-1:0] w_end_carga;

  gerador_endereco_contexto #(.PID_W(PID_W), .END_W(END_W), .CTX_BASE(CTX_BASE)) u_end_salva (
    .i_pid      (pid_salvar_q),
    .i_idx      (idx_q),
    .o_endereco (w_end_salva)
  );

  gerador_endereco_contexto #(.PID_W(PID_W), .END_W(END_W), .CTX_BASE(CTX_BASE)) u_end_carga (
    .i_pid      (pid_carregar_q),
    .i_idx      (w_idx_carga),
    .o_endereco (w_end_carga)
  );

  always_comb begin
    estado_d         = estado_q;
    idx_d            = idx_q;
    leitura_valida_d = leitura_valida_q;
    carrega_en_d     = carrega_en_q;
    pid_salvar_d     = pid_salvar_q;
    pid_carregar_d   = pid_carregar_q;
    w_idx_carga      = idx_q;
    bus.pronto       = 1'b0;
    bus.leituraUm    = '0;
    bus.regEscrita   = '0;
    bus.escreveReg   = 1'b0;
    bus.escreveDado  = '0;
    bus.memEnd       = '0;
    bus.memDadoEsc   = '0;
    bus.memEscreve   = 1'b0;

    if (bus.pausa) begin
      // memDadoLido is not held across a pause; the read is reissued on release
      leitura_valida_d = 1'b0;
    end else begin
      unique case (estado_q)
        OCIOSO: begin
          if (bus.inicia) begin
            pid_salvar_d     = bus.pidSalvar;
            pid_carregar_d   = bus.pidCarregar;
            carrega_en_d     = bus.carregaEn;
            idx_d            = IDX_W'(1);
            leitura_valida_d = 1'b0;
            if (bus.salvaEn)        estado_d = SALVA;
            else if (bus.carregaEn) estado_d = CARREGA;
            else                    estado_d = FIM;
          end
        end
        SALVA: begin
          bus.leituraUm  = idx_q;
          bus.memEnd     = w_end_salva;
          bus.memDadoEsc = bus.DadosUm;
          bus.memEscreve = 1'b1;
          if (idx_q == IDX_ULTIMO) begin
            idx_d    = IDX_W'(1);
            estado_d = carrega_en_q ? CARREGA : FIM;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        CARREGA: begin
          // idx_q == 0 stands for sub-cycle 32 (write-only for r31)
          if (idx_q != IDX_W'(1) && !leitura_valida_q) begin
            w_idx_carga      = idx_q - IDX_W'(1);
            bus.memEnd       = w_end_carga;
            leitura_valida_d = 1'b1;
          end else begin
            if (idx_q != IDX_W'(1)) begin
              bus.regEscrita  = idx_q - IDX_W'(1);
              bus.escreveDado = bus.memDadoLido;
              bus.escreveReg  = 1'b1;
            end
            if (idx_q != '0) begin
              bus.memEnd       = w_end_carga;
              leitura_valida_d = 1'b1;
              idx_d            = idx_q + IDX_W'(1);
            end else begin
              leitura_valida_d = 1'b0;
              estado_d         = FIM;
            end
          end
        end
        FIM: begin
          bus.pronto = 1'b1;
          estado_d   = OCIOSO;
        end
        default: estado_d = OCIOSO;
      endcase
    end
  end

  assign bus.ocupado = (estado_q != OCIOSO);

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q         <= OCIOSO;
      idx_q            <= '0;
      leitura_valida_q <= 1'b0;
      carrega_en_q     <= 1'b0;
      pid_salvar_q     <= '0;
      pid_carregar_q   <= '0;
    end else begin
      estado_q         <= estado_d;
      idx_q            <= idx_d;
      leitura_valida_q <= leitura_valida_d;
      carrega_en_q     <= carrega_en_d;
      pid_salvar_q     <= pid_salvar_d;
      pid_carregar_q   <= pid_carregar_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_controle_contexto.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_controle_contexto: transaction table plus reset/ignore sequences
// Rev 1.0
// ------------------------------------------------------------------
module tb_controle_contexto;

  logic clock;
  logic reset;
  logic init_req;
  logic clob_req;

  controle_contexto_if #(.PID_W(3), .END_W(32)) bus ();

  controle_contexto dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Environment: async-read register file and sync-read data memory at 0xF00..0xFFF
  logic [31:0] rf  [32];
  logic [31:0] mem [256];

  assign bus.DadosUm = rf[bus.leituraUm];

  always @(posedge clock) begin
    if (init_req) begin
      for (int n = 0; n < 32; n++) rf[n] <= (n == 0) ? 32'h0 : 32'h100 + n;
      for (int j = 0; j < 256; j++) mem[j] <= 32'hC0DE_0000 | j;
    end else if (clob_req) begin
      for (int n = 1; n < 32; n++) rf[n] <= 32'hDEAD_0000 | n;
    end else begin
      if (bus.memEscreve && bus.memEnd[31:8] == 24'h00000F) mem[bus.memEnd[7:0]] <= bus.memDadoEsc;
      if (bus.escreveReg) rf[bus.regEscrita] <= bus.escreveDado;
    end
    bus.memDadoLido <= (bus.memEnd[31:8] == 24'h00000F) ? mem[bus.memEnd[7:0]] : 32'h0;
  end

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    bit          s;
    bit          c;
    int          ps;
    int          pc;
    int          pause_edge;
    int          pause_len;
    int          pulse_edge;
    bit          clobber;
    logic [31:0] chk_base;
    int          lat;
  } tx_t;

  wr_t         exp_mw [$];
  wr_t         exp_rw [$];
  logic [31:0] exp_rf  [32];
  logic [31:0] exp_mem [256];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // One cycle: scoreboard check at negedge, then advance to #1 after posedge
  task automatic tick();
    wr_t w;
    @(negedge clock);
    if (bus.memEscreve) begin
      if (exp_mw.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL mem_wr_extra: got write to %h, required none", bus.memEnd);
      end else begin
        w = exp_mw.pop_front();
        check("mem_wr_addr", bus.memEnd, w.a);
        check("mem_wr_data", bus.memDadoEsc, w.d);
      end
    end
    if (bus.escreveReg) begin
      if (exp_rw.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL reg_wr_extra: got write to r%0d, required none", bus.regEscrita);
      end else begin
        w = exp_rw.pop_front();
        check("reg_wr_addr", 32'(bus.regEscrita), w.a);
        check("reg_wr_data", bus.escreveDado, w.d);
      end
    end
    if (bus.pausa) check("pause_strobes", {29'd0, bus.memEscreve, bus.escreveReg, bus.pronto}, 32'd0);
    @(posedge clock);
    #1;
  endtask

  task automatic push_expected(input bit s, input bit c, input int ps, input int pc);
    for (int n = 1; n < 32; n++) begin
      if (s) begin
        exp_mw.push_back({32'h0F00 + 32'(ps * 32 + n), exp_rf[n]});
        exp_mem[ps * 32 + n] = exp_rf[n];
      end
    end
    for (int n = 1; n < 32; n++) begin
      if (c) begin
        exp_rw.push_back({32'(n), exp_mem[pc * 32 + n]});
        exp_rf[n] = exp_mem[pc * 32 + n];
      end
    end
  endtask

  task automatic run_tx(input tx_t t);
    int n;
    int lat;
    bit done;
    if (t.clobber) begin
      clob_req = 1'b1;
      tick();
      clob_req = 1'b0;
      for (int k = 1; k < 32; k++) exp_rf[k] = 32'hDEAD_0000 | k;
    end
    push_expected(t.s, t.c, t.ps, t.pc);
    bus.inicia      = 1'b1;
    bus.salvaEn     = t.s;
    bus.carregaEn   = t.c;
    bus.pidSalvar   = 3'(t.ps);
    bus.pidCarregar = 3'(t.pc);
    tick();
    bus.inicia = 1'b0;
    check("ocupado_after_accept", 32'(bus.ocupado), 32'd1);
    n = 0; lat = 0; done = 1'b0;
    while (!done && n < 200) begin
      if (bus.pronto) begin
        done = 1'b1;
        lat  = n + 2;
      end else begin
        if (n == t.pause_edge) bus.pausa = 1'b1;
        if (n == t.pause_edge + t.pause_len) bus.pausa = 1'b0;
        bus.inicia = (n == t.pulse_edge);
        if (n == t.pulse_edge) begin
          bus.salvaEn = 1'b1; bus.carregaEn = 1'b1;
          bus.pidSalvar = 3'd7; bus.pidCarregar = 3'd7;
        end
        tick();
        n++;
      end
    end
    bus.inicia = 1'b0;
    bus.pausa  = 1'b0;
    check("latency", 32'(lat), 32'(t.lat));
    tick();
    check("pronto_one_cycle", 32'(bus.pronto), 32'd0);
    check("ocupado_after_fim", 32'(bus.ocupado), 32'd0);
    check("mem_writes_left", 32'(exp_mw.size()), 32'd0);
    check("reg_writes_left", 32'(exp_rw.size()), 32'd0);
    exp_mw.delete();
    exp_rw.delete();
    if (t.chk_base != 32'd0)
      for (int k = 1; k < 32; k++) check("rf_restored", rf[k], t.chk_base + 32'(k));
  endtask

  tx_t tbl [8];

  initial begin
    int pcount;
    //        s  c  ps pc  pause_e len pulse clob chk_base       lat
    tbl[0] = '{1, 0, 1, 0, -1,     0,  -1,   0,   32'h0,         33};
    tbl[1] = '{0, 1, 0, 1, -1,     0,  -1,   1,   32'h100,       34};
    tbl[2] = '{1, 1, 2, 5, -1,     0,  -1,   0,   32'h0,         65};
    tbl[3] = '{0, 0, 4, 6, -1,     0,  -1,   0,   32'h0,          2};
    tbl[4] = '{1, 1, 3, 3, 40,     3,  -1,   0,   32'hC0DE_00A0, 69};
    tbl[5] = '{0, 1, 0, 7, 31,     2,  -1,   0,   32'h0,         37};
    tbl[6] = '{1, 0, 0, 0, 5,      2,  -1,   0,   32'h0,         35};
    tbl[7] = '{1, 1, 6, 0, -1,     0,  10,   0,   32'h0,         65};

    for (int n = 0; n < 32; n++) exp_rf[n] = (n == 0) ? 32'h0 : 32'h100 + n;
    for (int j = 0; j < 256; j++) exp_mem[j] = 32'hC0DE_0000 | j;

    bus.inicia = 1'b0; bus.salvaEn = 1'b0; bus.carregaEn = 1'b0;
    bus.pidSalvar = '0; bus.pidCarregar = '0; bus.pausa = 1'b0;
    clob_req = 1'b0;
    init_req = 1'b1;
    reset    = 1'b1;
    @(posedge clock); #1;
    tick();
    init_req = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    check("rst_ocupado",     32'(bus.ocupado),     32'd0);
    check("rst_pronto",      32'(bus.pronto),      32'd0);
    check("rst_escreveReg",  32'(bus.escreveReg),  32'd0);
    check("rst_memEscreve",  32'(bus.memEscreve),  32'd0);
    check("rst_leituraUm",   32'(bus.leituraUm),   32'd0);
    check("rst_regEscrita",  32'(bus.regEscrita),  32'd0);
    check("rst_memEnd",      bus.memEnd,           32'd0);
    check("rst_memDadoEsc",  bus.memDadoEsc,       32'd0);
    check("rst_escreveDado", bus.escreveDado,      32'd0);

    for (int i = 0; i < 8; i++) run_tx(tbl[i]);

    // Reset while saving r7: back to idle, no pronto, no further strobes
    push_expected(1'b1, 1'b1, 5, 2);
    bus.inicia = 1'b1; bus.salvaEn = 1'b1; bus.carregaEn = 1'b1;
    bus.pidSalvar = 3'd5; bus.pidCarregar = 3'd2;
    tick();
    bus.inicia = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    check("midrst_leituraUm", 32'(bus.leituraUm), 32'd7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_ocupado", 32'(bus.ocupado), 32'd0);
    check("midrst_mem_left", 32'(exp_mw.size()), 32'd24);
    check("midrst_reg_left", 32'(exp_rw.size()), 32'd31);
    exp_mw.delete();
    exp_rw.delete();
    pcount = 0;
    for (int k = 0; k < 70; k++) begin
      if (bus.pronto) pcount++;
      tick();
    end
    check("midrst_no_pronto", 32'(pcount), 32'd0);
    check("r0_untouched", rf[0], 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
